micro_sequencer: RTL and testbench



---
 rtl/micro_sequencer_pkg.sv | 113 +++++++++++
 rtl/micro_sequencer.sv | 136 +++++++++++++
 tb/tb_micro_sequencer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/micro_sequencer_pkg.sv
// Shared types, control-word layout and pack/unpack helpers for the micro-sequencer.
// The layout matches the 25-bit words stored in the microcode ROM, MSB first.
package micro_sequencer_pkg;

    localparam int unsigned CW_W    = 25;
    localparam int unsigned OPC_W   = 5;
    localparam int unsigned STEP_W  = 4;
    localparam int unsigned UADDR_W = OPC_W + STEP_W;

    // Bit positions inside the packed control word
    localparam int unsigned CW_ADDR_OP_LSB   = 22;
    localparam int unsigned CW_ALU_OP_LSB    = 18;
    localparam int unsigned CW_ALU_EN        = 17;
    localparam int unsigned CW_MEM_OP_LSB    = 14;
    localparam int unsigned CW_DATA_WORD_SEL = 13;
    localparam int unsigned CW_BUS_SEL       = 12;
    localparam int unsigned CW_RAX_LSB       = 10;
    localparam int unsigned CW_RBX_LSB       = 8;
    localparam int unsigned CW_RCX_LSB       = 6;
    localparam int unsigned CW_RDX_LSB       = 4;
    localparam int unsigned CW_RESET         = 3;
    localparam int unsigned CW_HALT          = 2;
    localparam int unsigned CW_CU_LOAD       = 1;
    localparam int unsigned CW_NEXT_INSTR    = 0;

    localparam logic [2:0] MEM_NOP   = 3'd0;
    localparam logic [2:0] MEM_READ  = 3'd1;
    localparam logic [2:0] MEM_WRITE = 3'd2;

    typedef enum logic [2:0] {
        StIssue,
        StLatch,
        StExec,
        StMemWait,
        StHalted
    } useq_state_e;

    typedef enum logic [2:0] {
        AddrNop     = 3'd0,
        AddrLoadPc  = 3'd1,
        AddrIncPc   = 3'd2,
        AddrLoadMar = 3'd3,
        AddrPcToMar = 3'd4,
        AddrRsv5    = 3'd5,
        AddrRsv6    = 3'd6,
        AddrRsv7    = 3'd7
    } address_reg_op_e;

    typedef struct packed {
        address_reg_op_e addr_op;
        logic [3:0]      alu_op;
        logic            alu_en;
        logic [2:0]      mem_op;
        logic            data_word_sel;
        logic            bus_sel;
        logic [1:0]      rax;
        logic [1:0]      rbx;
        logic [1:0]      rcx;
        logic [1:0]      rdx;
        logic            reset;
        logic            halt;
        logic            cu_load;
        logic            next_instr;
    } control_word_t;

    function automatic control_word_t cw_unpack(input logic [CW_W-1:0] v);
        control_word_t c;
        c.addr_op       = address_reg_op_e'(v[CW_ADDR_OP_LSB +: 3]);
        c.alu_op        = v[CW_ALU_OP_LSB +: 4];
        c.alu_en        = v[CW_ALU_EN];
        c.mem_op        = v[CW_MEM_OP_LSB +: 3];
        c.data_word_sel = v[CW_DATA_WORD_SEL];
        c.bus_sel       = v[CW_BUS_SEL];
        c.rax           = v[CW_RAX_LSB +: 2];
        c.rbx           = v[CW_RBX_LSB +: 2];
        c.rcx           = v[CW_RCX_LSB +: 2];
        c.rdx           = v[CW_RDX_LSB +: 2];
        c.reset         = v[CW_RESET];
        c.halt          = v[CW_HALT];
        c.cu_load       = v[CW_CU_LOAD];
        c.next_instr    = v[CW_NEXT_INSTR];
        return c;
    endfunction

    function automatic logic [CW_W-1:0] cw_pack(input control_word_t c);
        logic [CW_W-1:0] v;
        v                          = '0;
        v[CW_ADDR_OP_LSB +: 3]     = c.addr_op;
        v[CW_ALU_OP_LSB +: 4]      = c.alu_op;
        v[CW_ALU_EN]               = c.alu_en;
        v[CW_MEM_OP_LSB +: 3]      = c.mem_op;
        v[CW_DATA_WORD_SEL]        = c.data_word_sel;
        v[CW_BUS_SEL]              = c.bus_sel;
        v[CW_RAX_LSB +: 2]         = c.rax;
        v[CW_RBX_LSB +: 2]         = c.rbx;
        v[CW_RCX_LSB +: 2]         = c.rcx;
        v[CW_RDX_LSB +: 2]         = c.rdx;
        v[CW_RESET]                = c.reset;
        v[CW_HALT]                 = c.halt;
        v[CW_CU_LOAD]              = c.cu_load;
        v[CW_NEXT_INSTR]           = c.next_instr;
        return v;
    endfunction

    function automatic logic mem_op_is_access(input logic [2:0] op);
        return (op == MEM_READ) || (op == MEM_WRITE);
    endfunction

    function automatic logic mem_op_is_valid(input logic [2:0] op);
        return (op == MEM_NOP) || mem_op_is_access(op);
    endfunction

endpackage

// File: rtl/micro_sequencer.sv
// Microcoded control unit: walks per-opcode routines in a synchronous ROM and commits one
// registered control word per micro-step, stalling on the memory handshake.
module micro_sequencer
    import micro_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    output logic [UADDR_W-1:0] uaddr_o,
    output logic               rom_en_o,
    input  logic [CW_W-1:0]    rom_data_i,
    input  logic [7:0]         ir_data_i,
    output logic               mem_req_o,
    input  logic               mem_ready_i,
    output logic [CW_W-1:0]    cw_o,
    output logic               cw_valid_o,
    output logic               halted_o,
    output logic               uerr_o
);

    localparam logic [STEP_W-1:0] STEP_MAX = '1;

    useq_state_e       state_q, state_d;
    logic [OPC_W-1:0]  opcode_q, opcode_d;
    logic [OPC_W-1:0]  opcode_pend_q, opcode_pend_d;
    logic [STEP_W-1:0] step_q, step_d;
    control_word_t     cw_q, cw_d;
    logic              uerr_q, uerr_d;

    logic              mem_access;
    logic              commit;
    logic [OPC_W-1:0]  ir_opcode;
    logic [OPC_W-1:0]  opcode_src;
    logic              unused_ir;

    assign ir_opcode  = ir_data_i[OPC_W-1:0];
    assign unused_ir  = ^ir_data_i[7:OPC_W];
    assign mem_access = mem_op_is_access(cw_q.mem_op);
    // Same-cycle cu_load bypasses opcode_pend so a fetch routine can load and jump at once.
    assign opcode_src = cw_q.cu_load ? ir_opcode : opcode_pend_q;

    always_comb begin
        commit = 1'b0;
        if (state_q == StExec) begin
            commit = !mem_access || mem_ready_i;
        end else if (state_q == StMemWait) begin
            commit = mem_ready_i;
        end
    end

    always_comb begin
        state_d       = state_q;
        opcode_d      = opcode_q;
        opcode_pend_d = opcode_pend_q;
        step_d        = step_q;
        cw_d          = cw_q;
        uerr_d        = uerr_q;

        unique case (state_q)
            StIssue: begin
                state_d = StLatch;
            end
            StLatch: begin
                cw_d    = cw_unpack(rom_data_i);
                state_d = StExec;
            end
            StExec, StMemWait: begin
                if (commit) begin
                    state_d = StIssue;
                    if (!mem_op_is_valid(cw_q.mem_op)) begin
                        uerr_d = 1'b1;
                    end
                    if (cw_q.reset) begin
                        opcode_d      = '0;
                        opcode_pend_d = '0;
                        step_d        = '0;
                        uerr_d        = 1'b0;
                    end else if (cw_q.halt) begin
                        state_d = StHalted;
                        cw_d    = '0;
                    end else begin
                        if (cw_q.cu_load) begin
                            opcode_pend_d = ir_opcode;
                        end
                        if (cw_q.next_instr) begin
                            step_d   = '0;
                            opcode_d = (opcode_q == '0) ? opcode_src : '0;
                        end else if (step_q == STEP_MAX) begin
                            // Routine ran off the end of its slot: flag it and refetch.
                            uerr_d   = 1'b1;
                            step_d   = '0;
                            opcode_d = '0;
                        end else begin
                            step_d = step_q + STEP_W'(1);
                        end
                    end
                end else begin
                    state_d = StMemWait;
                end
            end
            StHalted: begin
                state_d = StHalted;
            end
            default: begin
                state_d = StIssue;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIssue;
            opcode_q      <= '0;
            opcode_pend_q <= '0;
            step_q        <= '0;
            cw_q          <= '0;
            uerr_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            opcode_q      <= opcode_d;
            opcode_pend_q <= opcode_pend_d;
            step_q        <= step_d;
            cw_q          <= cw_d;
            uerr_q        <= uerr_d;
        end
    end

    // rst gates rom_en_o so the reset state (ISSUE) does not fire a ROM read.
    assign rom_en_o   = (state_q == StIssue) && !rst;
    assign mem_req_o  = ((state_q == StExec) && mem_access) || (state_q == StMemWait);
    assign uaddr_o    = {opcode_q, step_q};
    assign cw_o       = cw_pack(cw_q);
    assign cw_valid_o = commit;
    assign halted_o   = (state_q == StHalted);
    assign uerr_o     = uerr_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: a behavioural ROM, a table of micro-steps with
// hand-computed expectations, and hand-written reset/halt sequences.
module tb_micro_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [8:0]  uaddr_o;
    logic        rom_en_o;
    logic [24:0] rom_data_i;
    logic [7:0]  ir_data_i = 8'h00;
    logic        mem_req_o;
    logic        mem_ready_i = 1'b0;
    logic [24:0] cw_o;
    logic        cw_valid_o;
    logic        halted_o;
    logic        uerr_o;

    logic [24:0] rom_mem [512];

    int total = 0;
    int bad   = 0;

    localparam logic [3:0] C_NXT  = 4'b0001;
    localparam logic [3:0] C_LD   = 4'b0010;
    localparam logic [3:0] C_HALT = 4'b0100;
    localparam logic [3:0] C_RST  = 4'b1000;

    typedef struct {
        logic [8:0]  uaddr;
        logic [24:0] word;
        logic [7:0]  ir;
        int          dly;
        bit          early;
        int          req;
        bit          uerr;
    } vec_t;

    vec_t vecs[$];

    micro_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .uaddr_o    (uaddr_o),
        .rom_en_o   (rom_en_o),
        .rom_data_i (rom_data_i),
        .ir_data_i  (ir_data_i),
        .mem_req_o  (mem_req_o),
        .mem_ready_i(mem_ready_i),
        .cw_o       (cw_o),
        .cw_valid_o (cw_valid_o),
        .halted_o   (halted_o),
        .uerr_o     (uerr_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rom_en_o) rom_data_i <= rom_mem[uaddr_o];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [24:0] mk(input logic [2:0] addr_op, input logic [3:0] alu_op,
                                       input logic alu_en, input logic [2:0] mem_op,
                                       input logic [7:0] regs, input logic [3:0] ctl);
        return {addr_op, alu_op, alu_en, mem_op, 2'b00, regs, ctl};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [8:0] ua, input logic [24:0] w, input logic [7:0] ir,
                       input int dly, input bit early, input int req, input bit uerr);
        vec_t v;
        v.uaddr = ua; v.word = w; v.ir = ir; v.dly = dly;
        v.early = early; v.req = req; v.uerr = uerr;
        vecs.push_back(v);
    endtask

    // Entered at a sampling point inside an ISSUE cycle; leaves at the next ISSUE cycle.
    task automatic run_vec(input int i, input vec_t v);
        int  req_n;
        int  val_n;
        bit  done;
        chk($sformatf("v%0d rom_en", i), 32'(rom_en_o), 32'd1);
        chk($sformatf("v%0d uaddr", i), 32'(uaddr_o), 32'(v.uaddr));
        rom_mem[uaddr_o] = v.word;
        ir_data_i        = v.ir;
        mem_ready_i      = v.early;
        @(negedge clk);
        val_n = int'(cw_valid_o);
        req_n = 0;
        done  = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d cw", i), 32'(cw_o), 32'(v.word));
        for (int c = 0; c < 40 && !done; c++) begin
            if (c > 0) @(negedge clk);
            mem_ready_i = (c >= v.dly);
            #1;
            if (mem_req_o) req_n++;
            if (cw_valid_o) begin
                val_n++;
                done = 1'b1;
            end
        end
        chk($sformatf("v%0d commit seen", i), 32'(done), 32'd1);
        chk($sformatf("v%0d req cycles", i), 32'(req_n), 32'(v.req));
        @(negedge clk);
        mem_ready_i = 1'b0;
        #1;
        val_n += int'(cw_valid_o);
        chk($sformatf("v%0d valid pulses", i), 32'(val_n), 32'd1);
        chk($sformatf("v%0d uerr", i), 32'(uerr_o), 32'(v.uerr));
    endtask

    initial begin
        logic [24:0] w;
        int          act;

        for (int a = 0; a < 512; a++) rom_mem[a] = '0;

        add(9'h001, mk(0, 0, 0, 3'd1, 8'h00, C_LD | C_NXT), 8'h03, 4, 1, 5, 0);
        add(9'h030, mk(1, 4'h2, 1, 3'd2, 8'h00, 4'h0), 8'h03, 0, 0, 1, 0);
        add(9'h031, mk(0, 4'h3, 1, 3'd6, 8'h5A, 4'h0), 8'h00, 0, 0, 0, 1);
        add(9'h032, mk(0, 0, 0, 3'd0, 8'h00, C_NXT), 8'h1F, 0, 0, 0, 1);
        add(9'h000, mk(0, 0, 0, 3'd0, 8'h00, C_RST | C_LD), 8'h07, 0, 0, 0, 0);
        add(9'h000, mk(2, 0, 0, 3'd0, 8'h00, C_NXT), 8'h09, 0, 0, 0, 0);
        add(9'h000, mk(0, 0, 0, 3'd0, 8'h00, C_LD | C_NXT), 8'h05, 0, 0, 0, 0);
        for (int s = 0; s < 16; s++) begin
            add(9'h050 + 9'(s), mk(3'(s), 4'(s), 1, 3'd0, 8'(s * 17), 4'h0), 8'h00, 0, 0, 0,
                (s == 15));
        end
        add(9'h000, mk(0, 0, 0, 3'd0, 8'h00, C_RST), 8'h00, 0, 0, 0, 0);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst rom_en", 32'(rom_en_o), 32'd0);
        chk("rst mem_req", 32'(mem_req_o), 32'd0);
        chk("rst cw_valid", 32'(cw_valid_o), 32'd0);
        chk("rst halted", 32'(halted_o), 32'd0);
        chk("rst uerr", 32'(uerr_o), 32'd0);
        chk("rst cw", 32'(cw_o), 32'd0);
        chk("rst uaddr", 32'(uaddr_o), 32'd0);

        // First micro-step: three-cycle cadence
        w = mk(0, 4'h1, 1, 3'd0, 8'h00, 4'h0);
        rom_mem[0] = w;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("c1 rom_en", 32'(rom_en_o), 32'd1);
        chk("c1 uaddr", 32'(uaddr_o), 32'h000);
        @(negedge clk);
        chk("c2 rom_en", 32'(rom_en_o), 32'd0);
        chk("c2 cw_valid", 32'(cw_valid_o), 32'd0);
        @(negedge clk);
        chk("c3 cw_valid", 32'(cw_valid_o), 32'd1);
        chk("c3 cw", 32'(cw_o), 32'(w));
        @(negedge clk);
        chk("c4 uaddr", 32'(uaddr_o), 32'h001);
        chk("c4 cw_valid", 32'(cw_valid_o), 32'd0);

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // rst while waiting on memory
        chk("mw uaddr", 32'(uaddr_o), 32'h000);
        rom_mem[0] = mk(0, 0, 0, 3'd1, 8'h00, C_LD | C_NXT);
        ir_data_i  = 8'h04;
        @(negedge clk);
        @(negedge clk);
        mem_ready_i = 1'b0;
        #1 chk("mw exec req", 32'(mem_req_o), 32'd1);
        @(negedge clk);
        #1 chk("mw wait req", 32'(mem_req_o), 32'd1);
        chk("mw wait valid", 32'(cw_valid_o), 32'd0);
        rst = 1'b1;
        #1;
        chk("mw rst req", 32'(mem_req_o), 32'd0);
        chk("mw rst rom_en", 32'(rom_en_o), 32'd0);
        chk("mw rst cw", 32'(cw_o), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mw post rom_en", 32'(rom_en_o), 32'd1);
        chk("mw post uaddr", 32'(uaddr_o), 32'h000);

        // Halt wins over next_instr/cu_load; only rst leaves HALTED
        w = mk(1, 4'hF, 1, 3'd0, 8'hFF, C_HALT | C_LD | C_NXT);
        rom_mem[0] = w;
        ir_data_i  = 8'h06;
        @(negedge clk);
        @(negedge clk);
        #1 chk("h commit", 32'(cw_valid_o), 32'd1);
        chk("h cw", 32'(cw_o), 32'(w));
        @(negedge clk);
        #1 chk("h halted", 32'(halted_o), 32'd1);
        chk("h cw cleared", 32'(cw_o), 32'd0);
        act = 0;
        repeat (20) begin
            @(negedge clk);
            mem_ready_i = 1'b1;
            #1;
            if (rom_en_o || mem_req_o || cw_valid_o) act++;
        end
        mem_ready_i = 1'b0;
        chk("h activity", 32'(act), 32'd0);
        chk("h still halted", 32'(halted_o), 32'd1);
        rst = 1'b1;
        #1 chk("h rst halted", 32'(halted_o), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("h post uaddr", 32'(uaddr_o), 32'h000);
        chk("h post rom_en", 32'(rom_en_o), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
